// File: rtl/vga_timing_gen.sv
// VGA raster generator: column/row counters, sync and blanking decode,
// line/frame start pulses, and blanked, registered RGB aligned with sync.
module vga_timing_gen #(
    parameter int unsigned VIDEO_WIDTH      = 4,
    parameter int unsigned TOTAL_COLS       = 800,
    parameter int unsigned TOTAL_ROWS       = 525,
    parameter int unsigned ACTIVE_COLS      = 640,
    parameter int unsigned ACTIVE_ROWS      = 480,
    parameter int unsigned FRONT_PORCH_HORZ = 18,
    parameter int unsigned BACK_PORCH_HORZ  = 50,
    parameter int unsigned FRONT_PORCH_VERT = 10,
    parameter int unsigned BACK_PORCH_VERT  = 33
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset,
    input  logic                   i_Enable,
    input  logic [VIDEO_WIDTH-1:0] i_Red_Video,
    input  logic [VIDEO_WIDTH-1:0] i_Grn_Video,
    input  logic [VIDEO_WIDTH-1:0] i_Blu_Video,
    output logic [9:0]             o_Req_Col,
    output logic [9:0]             o_Req_Row,
    output logic [9:0]             o_Col_Count,
    output logic [9:0]             o_Row_Count,
    output logic                   o_HSync,
    output logic                   o_VSync,
    output logic                   o_Active,
    output logic                   o_Line_Start,
    output logic                   o_Frame_Start,
    output logic [VIDEO_WIDTH-1:0] o_Red_Video,
    output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
    output logic [VIDEO_WIDTH-1:0] o_Blu_Video
);

    localparam logic [9:0] COL_LAST     = 10'(TOTAL_COLS - 1);
    localparam logic [9:0] ROW_LAST     = 10'(TOTAL_ROWS - 1);
    localparam logic [9:0] H_ACTIVE     = 10'(ACTIVE_COLS);
    localparam logic [9:0] V_ACTIVE     = 10'(ACTIVE_ROWS);
    localparam logic [9:0] H_SYNC_FIRST = 10'(ACTIVE_COLS + FRONT_PORCH_HORZ);
    localparam logic [9:0] H_SYNC_LAST  = 10'(TOTAL_COLS - BACK_PORCH_HORZ - 1);
    localparam logic [9:0] V_SYNC_FIRST = 10'(ACTIVE_ROWS + FRONT_PORCH_VERT);
    localparam logic [9:0] V_SYNC_LAST  = 10'(TOTAL_ROWS - BACK_PORCH_VERT - 1);

    logic [9:0] col_count;
    logic [9:0] row_count;
    logic       col_wrap;
    logic       row_wrap;
    logic       pix_active;
    logic       pix_hsync_n;
    logic       pix_vsync_n;

    // Decode the current counter position into blanking and sync levels
    always_comb begin
        col_wrap    = (col_count == COL_LAST);
        row_wrap    = (row_count == ROW_LAST);
        pix_active  = (col_count < H_ACTIVE) && (row_count < V_ACTIVE);
        pix_hsync_n = !((col_count >= H_SYNC_FIRST) && (col_count <= H_SYNC_LAST));
        pix_vsync_n = !((row_count >= V_SYNC_FIRST) && (row_count <= V_SYNC_LAST));
    end

    // Raster counters: column wraps each line, row advances on column wrap
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            col_count <= '0;
            row_count <= '0;
        end else if (i_Enable) begin
            if (col_wrap) begin
                col_count <= '0;
                row_count <= row_wrap ? '0 : row_count + 10'd1;
            end else begin
                col_count <= col_count + 10'd1;
            end
        end
    end

    // Register the decode of the current pixel; pulses drop on any following edge
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_Col_Count   <= '0;
            o_Row_Count   <= '0;
            o_HSync       <= 1'b1;
            o_VSync       <= 1'b1;
            o_Active      <= 1'b0;
            o_Line_Start  <= 1'b0;
            o_Frame_Start <= 1'b0;
            o_Red_Video   <= '0;
            o_Grn_Video   <= '0;
            o_Blu_Video   <= '0;
        end else begin
            o_Line_Start  <= 1'b0;
            o_Frame_Start <= 1'b0;
            if (i_Enable) begin
                o_Col_Count   <= col_count;
                o_Row_Count   <= row_count;
                o_HSync       <= pix_hsync_n;
                o_VSync       <= pix_vsync_n;
                o_Active      <= pix_active;
                o_Line_Start  <= (col_count == '0);
                o_Frame_Start <= (col_count == '0) && (row_count == '0);
                o_Red_Video   <= pix_active ? i_Red_Video : '0;
                o_Grn_Video   <= pix_active ? i_Grn_Video : '0;
                o_Blu_Video   <= pix_active ? i_Blu_Video : '0;
            end
        end
    end

    assign o_Req_Col = col_count;
    assign o_Req_Row = row_count;

endmodule
